// File: rtl/usbf_dma_arb_pkg.sv
// Shared types, default parameters and helpers for the endpoint DMA arbiter.
package usbf_dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    SETTLE = 2'd2
  } arb_state_t;

  localparam int NEP_DEF   = 4;
  localparam int EPW_DEF   = 2;
  localparam int BURST_DEF = 8;
  localparam int TOW_DEF   = 10;

  // Endpoint index increment that wraps at n, which need not be a power of two.
  function automatic int mod_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/usbf_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NEP.
module usbf_rr_pick #(
  parameter int NEP = usbf_dma_arb_pkg::NEP_DEF,
  parameter int EPW = usbf_dma_arb_pkg::EPW_DEF
) (
  input  logic [NEP-1:0] req,
  input  logic [EPW-1:0] ptr,
  output logic           valid,
  output logic [EPW-1:0] idx
);

  logic [NEP-1:0] rot;
  int             off;
  int             sum;

  // Bit j of rot is the request of endpoint (ptr + j) mod NEP.
  assign rot = NEP'({req, req} >> ptr);

  always_comb begin
    valid = 1'b0;
    off   = 0;
    sum   = 0;
    idx   = '0;
    for (int j = 0; j < NEP; j++) begin
      if (!valid && rot[j]) begin
        valid = 1'b1;
        off   = j;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= NEP) sum = sum - NEP;
    idx = EPW'(sum);
  end

endmodule

// File: rtl/usbf_dma_arb.sv
// Round-robin arbiter sharing one DMA master among NEP endpoint register files,
// with a per-grant burst limit and a no-ack watchdog.
module usbf_dma_arb
  import usbf_dma_arb_pkg::*;
#(
  parameter int NEP   = NEP_DEF,
  parameter int EPW   = EPW_DEF,
  parameter int BURST = BURST_DEF,
  parameter int TOW   = TOW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NEP-1:0] ep_req,
  input  logic [NEP-1:0] ep_en,
  output logic [NEP-1:0] ep_ack,
  output logic           m_req,
  output logic [EPW-1:0] m_ep,
  input  logic           m_ack,
  output logic           busy,
  output logic           to_err
);

  // Handshake: each m_ack pulse while m_req=1 completes one word for endpoint m_ep;
  // m_ack at any other time carries no meaning and is dropped.

  arb_state_t     state;
  logic [EPW-1:0] rr_ptr;
  logic [7:0]     burst_cnt;
  logic [TOW-1:0] wd_cnt;
  logic [NEP-1:0] eff;
  logic           pick_valid;
  logic [EPW-1:0] pick_idx;
  logic           gnt_req;
  logic [EPW-1:0] next_ptr;

  assign eff      = ep_req & ep_en;
  assign gnt_req  = eff[m_ep];
  assign next_ptr = EPW'(mod_inc(int'(m_ep), NEP));

  usbf_rr_pick #(.NEP(NEP), .EPW(EPW)) u_pick (
    .req   (eff),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // m_req is registered and cleared by reset, so the ack path dies with it.
  always_comb begin
    ep_ack = '0;
    if (m_req && m_ack) ep_ack[m_ep] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      m_req     <= 1'b0;
      m_ep      <= '0;
      busy      <= 1'b0;
      to_err    <= 1'b0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      wd_cnt    <= '0;
    end else begin
      to_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            m_ep      <= pick_idx;
            burst_cnt <= '0;
            wd_cnt    <= '0;
            m_req     <= 1'b1;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (m_ack) begin
            burst_cnt <= burst_cnt + 8'd1;
            wd_cnt    <= '0;
            m_req     <= 1'b0;
            state     <= SETTLE;
          end else if (!gnt_req) begin
            rr_ptr <= next_ptr;
            m_req  <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (&wd_cnt) begin
            to_err <= 1'b1;
            rr_ptr <= next_ptr;
            m_req  <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + TOW'(1);
          end
        end
        SETTLE: begin
          // One dead cycle lets the endpoint's registered request fall after the ack.
          if (gnt_req && (burst_cnt < 8'(BURST))) begin
            m_req <= 1'b1;
            state <= BUSY;
          end else begin
            rr_ptr    <= next_ptr;
            burst_cnt <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          m_req <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Bench for usbf_dma_arb: vector table, directed corner sequences, random run vs reference model.
module tb_usbf_dma_arb;

  localparam int NEP   = 4;
  localparam int EPW   = 2;
  localparam int BURST = 8;
  localparam int TOW   = 10;

  logic           clk;
  logic           rst;
  logic [NEP-1:0] ep_req;
  logic [NEP-1:0] ep_en;
  logic [NEP-1:0] ep_ack;
  logic           m_req;
  logic [EPW-1:0] m_ep;
  logic           m_ack;
  logic           busy;
  logic           to_err;

  int total = 0;
  int bad   = 0;

  usbf_dma_arb #(.NEP(NEP), .EPW(EPW), .BURST(BURST), .TOW(TOW)) dut (
    .clk    (clk),
    .rst    (rst),
    .ep_req (ep_req),
    .ep_en  (ep_en),
    .ep_ack (ep_ack),
    .m_req  (m_req),
    .m_ep   (m_ep),
    .m_ack  (m_ack),
    .busy   (busy),
    .to_err (to_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; ep_req = '0; ep_en = '0; m_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // driver: apply one cycle of inputs at the falling edge, settle, then caller samples
  task automatic cycle_set(input logic [NEP-1:0] req, input logic [NEP-1:0] en, input logic ack);
    @(negedge clk);
    ep_req = req; ep_en = en; m_ack = ack;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] outs();
    return {m_req, m_ep, busy, to_err, ep_ack};
  endfunction

  // reference model: who owns the channel, whether it is in the post-ack gap, words and quiet cycles
  int mo_owner, mo_ptr, mo_words, mo_quiet, mo_last;
  bit mo_gap, mo_err;

  task automatic model_reset();
    mo_owner = -1; mo_ptr = 0; mo_words = 0; mo_quiet = 0; mo_last = 0;
    mo_gap = 1'b0; mo_err = 1'b0;
  endtask

  function automatic logic [8:0] model_out(input logic ack);
    logic           mreq;
    logic [NEP-1:0] av;
    mreq = (mo_owner >= 0) && !mo_gap;
    av   = (mreq && ack) ? (NEP'(1) << mo_owner) : '0;
    return {mreq, 2'(mo_last), mo_owner >= 0, mo_err, av};
  endfunction

  task automatic model_step(input logic [NEP-1:0] eff, input logic ack);
    mo_err = 1'b0;
    if (mo_owner < 0) begin
      for (int i = 0; i < NEP; i++) begin
        if (mo_owner < 0 && eff[(mo_ptr + i) % NEP]) begin
          mo_owner = (mo_ptr + i) % NEP;
          mo_last = mo_owner; mo_words = 0; mo_quiet = 0; mo_gap = 1'b0;
        end
      end
    end else if (!mo_gap) begin
      if (ack) begin
        mo_words++; mo_quiet = 0; mo_gap = 1'b1;
      end else if (!eff[mo_owner]) begin
        mo_ptr = (mo_owner + 1) % NEP; mo_owner = -1;
      end else if (mo_quiet == (1 << TOW) - 1) begin
        mo_err = 1'b1; mo_ptr = (mo_owner + 1) % NEP; mo_owner = -1;
      end else begin
        mo_quiet++;
      end
    end else begin
      mo_gap = 1'b0;
      if (!(eff[mo_owner] && mo_words < BURST)) begin
        mo_ptr = (mo_owner + 1) % NEP; mo_owner = -1;
      end
    end
  endtask

  typedef struct packed {
    logic [NEP-1:0] req;
    logic [NEP-1:0] en;
    logic           ack;
    logic           e_mreq;
    logic [EPW-1:0] e_mep;
    logic           e_busy;
    logic           e_err;
    logic [NEP-1:0] e_ack;
  } vec_t;

  vec_t vecs[21];
  logic [NEP-1:0] exp_q[$];

  initial begin
    int k, prev_t, high, errs;
    bit drop_seen;
    logic [NEP-1:0] rr, re;
    logic ra;
    logic [8:0] e;

    rst = 1'b1; ep_req = '0; ep_en = '0; m_ack = 1'b0;

    //            req      en       ack  mreq ep    busy err ack
    vecs[0]  = '{4'b0100, 4'hF,    1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0100, 4'hF,    1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0100};
    vecs[2]  = '{4'b0100, 4'hF,    1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0000};
    vecs[3]  = '{4'b0100, 4'hF,    1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000};
    vecs[4]  = '{4'b0100, 4'hF,    1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0100};
    vecs[5]  = '{4'b0100, 4'hF,    1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0000};
    vecs[6]  = '{4'b0100, 4'hF,    1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0100};
    vecs[7]  = '{4'b0000, 4'hF,    1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0000};
    vecs[8]  = '{4'b0000, 4'hF,    1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 4'b0000};
    vecs[9]  = '{4'b1001, 4'hF,    1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 4'b0000};
    vecs[10] = '{4'b1000, 4'hF,    1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 4'b0000};
    vecs[11] = '{4'b0000, 4'hF,    1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 4'b0000};
    vecs[12] = '{4'b1001, 4'hF,    1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 4'b0000};
    vecs[13] = '{4'b1001, 4'hF,    1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000};
    vecs[14] = '{4'b0011, 4'b0010, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000};
    vecs[15] = '{4'b0011, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000};
    vecs[16] = '{4'b0011, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0010};
    vecs[17] = '{4'b0011, 4'b0010, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 4'b0000};
    vecs[18] = '{4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0010};
    vecs[19] = '{4'b0000, 4'b0010, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 4'b0000};
    vecs[20] = '{4'b0000, 4'b0010, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 4'b0000};

    // table-driven vectors
    do_reset();
    for (int i = 0; i < 21; i++) begin
      cycle_set(vecs[i].req, vecs[i].en, vecs[i].ack);
      check($sformatf("vec[%0d]", i), outs(),
            {vecs[i].e_mreq, vecs[i].e_mep, vecs[i].e_busy, vecs[i].e_err, vecs[i].e_ack});
    end

    // all four requesting, master acks continuously: BURST words per endpoint in rotation
    do_reset();
    for (int g = 0; g < 5; g++)
      for (int w = 0; w < BURST; w++) exp_q.push_back(NEP'(1) << (g % NEP));
    k = 0; prev_t = 0;
    for (int cyc = 0; cyc < 200 && k < 5 * BURST; cyc++) begin
      cycle_set(4'hF, 4'hF, 1'b1);
      if (ep_ack != '0) begin
        check("rot_ack", ep_ack, exp_q.pop_front());
        // within a burst acks are 2 cycles apart; across grants an extra IDLE cycle
        if (k > 0) check("rot_gap", cyc - prev_t, (k % BURST == 0) ? 3 : 2);
        prev_t = cyc;
        k++;
      end
    end
    check("rot_count", k, 5 * BURST);

    // watchdog: endpoint 1 granted, never acked; endpoint 2 waits
    do_reset();
    high = 0; errs = 0; drop_seen = 1'b0;
    for (int cyc = 0; cyc < 1200 && !drop_seen; cyc++) begin
      cycle_set(4'b0110, 4'hF, 1'b0);
      if (to_err) errs++;
      if (m_req) begin
        check("wd_mep", m_ep, 1);
        high++;
      end else if (high > 0) begin
        drop_seen = 1'b1;
        check("wd_err_at_drop", to_err, 1);
      end
    end
    check("wd_seen", drop_seen, 1);
    check("wd_busy_cycles", high, 1 << TOW);
    cycle_set(4'b0110, 4'hF, 1'b0);
    check("wd_next_grant", {m_req, m_ep, to_err}, {1'b1, 2'd2, 1'b0});
    check("wd_err_pulses", errs, 1);

    // stray ack in IDLE, then reset during a grant
    do_reset();
    cycle_set(4'b0000, 4'hF, 1'b1);
    check("stray_ack", outs(), 9'd0);
    cycle_set(4'b1000, 4'hF, 1'b0);
    cycle_set(4'b1000, 4'hF, 1'b0);
    check("pre_rst_grant", {m_req, m_ep}, {1'b1, 2'd3});
    @(negedge clk);
    m_ack = 1'b1; rst = 1'b0;
    #1;
    check("rst_async", outs(), 9'd0);
    @(negedge clk);
    check("rst_held", outs(), 9'd0);
    ep_req = '0; m_ack = 1'b0; rst = 1'b1;
    cycle_set(4'b0000, 4'hF, 1'b0);
    check("post_rst", outs(), 9'd0);

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rr = NEP'($urandom_range(0, 15));
      re = ($urandom_range(0, 7) == 0) ? NEP'($urandom_range(0, 15)) : 4'hF;
      ra = ($urandom_range(0, 2) != 0);
      cycle_set(rr, re, ra);
      e = model_out(ra);
      check($sformatf("rand[%0d]", cyc), outs(), e);
      model_step(rr & re, ra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usbf_dma_arb.md
Name: usbf_dma_arb

Overview:
- Round-robin arbiter that shares one external DMA channel among NEP endpoint register files.
- Each endpoint file raises a level request (dma_req) and expects one dma_ack pulse per 32-bit word moved.
- The block grants one endpoint at a time, presents its index to the shared DMA master, and routes master acks back to the granted endpoint.
- It enforces a per-grant burst limit and a no-ack watchdog, so no endpoint can starve the others or hang the channel.

Parameters:
- NEP, 4, number of endpoint requesters (2..16).
- EPW, 2, width of endpoint index; equals clog2(NEP).
- BURST, 8, maximum words per grant before rotating (1..255).
- TOW, 10, watchdog counter width; timeout = 2**TOW-1 cycles without ack.

Ports:
- clk  in  1  core clock (same domain as endpoint dma_req/dma_ack).
- rst  in  1  asynchronous, active-low reset.
- ep_req  in  NEP  level DMA request from each endpoint register file.
- ep_en  in  NEP  per-endpoint arbitration enable; a masked request is never granted.
- ep_ack  out  NEP  one-cycle word ack to the granted endpoint.
- m_req  out  1  request to the shared DMA master.
- m_ep  out  EPW  index of the granted endpoint, stable while m_req=1.
- m_ack  in  1  one-cycle word-done pulse from the DMA master.
- busy  out  1  high whenever state != IDLE.
- to_err  out  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Reset values: state=IDLE, m_req=0, m_ep=0, ep_ack=0, busy=0, to_err=0, rr_ptr=0, burst_cnt=0, wd_cnt=0.
- Effective request: eff = ep_req & ep_en.
- State IDLE:
  - If eff != 0, pick the first set bit at or after rr_ptr, wrapping modulo NEP.
  - On the next edge: register gnt=pick, m_ep=pick, burst_cnt=0, wd_cnt=0, go to BUSY.
  - Latency from request to m_req is 1 cycle.
- State BUSY:
  - m_req=1.
  - ep_ack[gnt] = m_ack, combinational pass-through, same cycle; all other ep_ack bits are 0.
  - On m_ack: burst_cnt+1, wd_cnt=0, go to SETTLE.
  - If eff[gnt]=0 with no m_ack (endpoint dropped or disabled): go to IDLE, rr_ptr=gnt+1.
  - If wd_cnt reaches all-ones with no m_ack: to_err=1 for one cycle, rr_ptr=gnt+1, go to IDLE.
  - Otherwise wd_cnt+1.
- State SETTLE (exactly 1 cycle):
  - m_req=0; this lets the endpoint's registered dma_req clear after the ack.
  - If eff[gnt]=1 and burst_cnt < BURST: go to BUSY with the same gnt.
  - Otherwise: rr_ptr=gnt+1 (wrapping at NEP), burst_cnt=0, go to IDLE.
- m_ack outside BUSY is ignored: no ep_ack, no counter change.
- m_ack and eff[gnt] falling in the same BUSY cycle: the ack is forwarded and counted, and the transition is to SETTLE.
- rr_ptr wraps from NEP-1 to 0; index width arithmetic is modulo NEP (not 2**EPW when NEP is not a power of 2).
- m_ep holds its last value in IDLE and SETTLE.
- Reset asserted mid-grant: all state clears immediately. m_req and ep_ack drop asynchronously, and no pending ack is forwarded after reset.
- Single requester: gets back-to-back grants separated by one IDLE cycle after every BURST words.

Decomposition:
- Package usbf_dma_arb_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, SETTLE=2'd2);
  - the NEP/EPW/BURST/TOW defaults;
  - a function for the modulo-NEP increment.
- One sub-module, usbf_rr_pick: combinational round-robin first-set picker.
  - Inputs: req[NEP], ptr[EPW].
  - Outputs: valid, idx[EPW].

Test Plan:
- Reset, then ep_req=4'b0100, ep_en=4'hF → m_req rises 1 cycle later with m_ep=2. Master acks 3 words while req is held; ep_ack[2] pulses ×3 coincident with m_ack; m_req low for 1 cycle after each ack.
- ep_req=4'b1111 held, master acks every BUSY cycle, BURST=8 → grants rotate 0,1,2,3,0 with exactly 8 ep_ack pulses each and one IDLE cycle between grants.
- ep_req=4'b0011, ep_en=4'b0010 → only endpoint 1 is granted; ep_ack[0] is never asserted.
- Grant endpoint 3, drop ep_req[3] before any ack → IDLE next cycle; a following ep_req=4'b1001 grants endpoint 0 (rr_ptr wrapped).
- Grant endpoint 1, master never acks → to_err pulses once at cycle 1023 of BUSY, m_req drops, and endpoint 2 is granted next if it is requesting.
- Stray m_ack in IDLE, then rst pulsed low during BUSY → no ep_ack on either event; all outputs are 0 while rst is low and m_ep=0 after release.
